// File: rtl/bp_pkg.sv
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the gshare speculative branch
//                predictor: BTB entry layout, branch-type and next-PC-select
//                encodings, and the PHT counter reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    // Control-transfer class stored with each BTB entry.
    typedef enum logic [1:0] {
        BR_COND   = 2'd0,
        BR_UNCOND = 2'd1,
        BR_CALL   = 2'd2,
        BR_RET    = 2'd3
    } br_type_e;

    // Next-PC source select presented to the fetch stage.
    typedef enum logic [1:0] {
        SEL_IF_PC4        = 2'b00,
        SEL_EXMEM_PC4     = 2'b01,
        SEL_IF_TARGET     = 2'b10,
        SEL_EXMEM_TARGET  = 2'b11
    } pcnext_sel_e;

    // Tags are held at the widest possible size (PC[31:2]) and zero-extended,
    // so one struct serves every INDEX_WIDTH.
    localparam int c_BTB_TAG_MAX = 30;

    typedef struct packed {
        logic                     valid;
        logic [c_BTB_TAG_MAX-1:0] tag;
        logic [31:0]              target;
        br_type_e                 btype;
    } btb_entry_t;

    // Weakly-not-taken value for a counter of the given width: 2^(w-1)-1.
    function automatic int unsigned ctr_weak_nt(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push when full overwrites
//                the oldest entry (pointer wraps, count saturates); a pop when
//                empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_push_addr,
    output logic [31:0] o_top,
    output logic        o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [31:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;      // next free slot
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic               w_do_pop;

    assign w_top_idx = (r_ptr == '0) ? c_PTR_LAST : r_ptr - 1'b1;
    assign w_ptr_inc = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;

    // Stack storage: written at the free slot on push, no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_push_addr;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= w_ptr_inc;
            if (r_count != c_CNT_FULL) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_do_pop) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gshare_spec_predictor.sv
// ============================================================================
//  Module      : gshare_spec_predictor
//  Description : Gshare direction predictor with speculative global history,
//                tagged BTB, commit-time training and mispredict recovery.
//                Define RAS_EN to add a return-address stack (ras_stack) that
//                supplies return targets; without it returns use the BTB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_spec_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH   = 6,
    parameter int HISTORY_WIDTH = 8,
    parameter int CTR_WIDTH     = 2,
    parameter int RAS_DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              IF_pc_i,
    input  logic                     IF_valid_i,
    input  logic                     EXMEM_valid_i,
    input  logic [31:0]              EXMEM_pc_i,
    input  logic                     EXMEM_is_br_i,
    input  logic                     EXMEM_is_jmp_i,
    input  logic                     EXMEM_is_call_i,
    input  logic                     EXMEM_is_ret_i,
    input  logic                     EXMEM_taken_i,
    input  logic [31:0]              EXMEM_target_i,
    input  logic                     EXMEM_prediction_i,
    input  logic [31:0]              EXMEM_pred_target_i,
    input  logic [HISTORY_WIDTH-1:0] EXMEM_ghr_i,
    output logic                     IF_btb_hit_o,
    output logic                     IF_prediction_o,
    output logic [31:0]              IF_target_o,
    output logic [HISTORY_WIDTH-1:0] IF_ghr_o,
    output logic [1:0]               IF_PCnext_sel_o,
    output logic                     IF_flush_o
);

    localparam int c_BTB_ENTRIES = 1 << INDEX_WIDTH;
    localparam int c_PHT_ENTRIES = 1 << HISTORY_WIDTH;
    localparam logic [CTR_WIDTH-1:0] c_CTR_RESET = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] c_CTR_MAX   = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    btb_entry_t               r_btb [c_BTB_ENTRIES];
    logic [CTR_WIDTH-1:0]     r_pht [c_PHT_ENTRIES];
    logic [HISTORY_WIDTH-1:0] r_spec_ghr;

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0]   w_if_btb_idx;
    logic [c_BTB_TAG_MAX-1:0] w_if_tag;
    btb_entry_t               w_if_entry;
    logic                     w_if_hit;
    logic [HISTORY_WIDTH-1:0] w_if_pht_idx;
    logic [CTR_WIDTH-1:0]     w_if_ctr;
    logic                     w_if_pred;
    logic                     w_if_cond_shift;

    assign w_if_btb_idx = IF_pc_i[INDEX_WIDTH+1:2];
    assign w_if_tag     = c_BTB_TAG_MAX'(IF_pc_i[31:INDEX_WIDTH+2]);
    assign w_if_entry   = r_btb[w_if_btb_idx];
    assign w_if_hit     = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign w_if_pht_idx = IF_pc_i[HISTORY_WIDTH+1:2] ^ r_spec_ghr;
    assign w_if_ctr     = r_pht[w_if_pht_idx];
    assign w_if_pred    = w_if_hit &&
                          ((w_if_entry.btype != BR_COND) || w_if_ctr[CTR_WIDTH-1]);

    // ------------------------------------------------------------------
    // Commit-side resolution
    // ------------------------------------------------------------------
    logic                     w_ex_ctl;
    logic                     w_mispredict;
    logic [HISTORY_WIDTH-1:0] w_ex_pht_idx;
    logic                     w_pht_upd;
    logic                     w_btb_wr;
    logic [INDEX_WIDTH-1:0]   w_ex_btb_idx;
    br_type_e                 w_ex_type;
    btb_entry_t               w_ex_entry;
    pcnext_sel_e              w_sel;

    assign w_ex_ctl     = EXMEM_is_br_i || EXMEM_is_jmp_i;
    assign w_mispredict = EXMEM_valid_i && w_ex_ctl &&
                          ((EXMEM_prediction_i != EXMEM_taken_i) ||
                           (EXMEM_taken_i && (EXMEM_pred_target_i != EXMEM_target_i)));
    assign w_ex_pht_idx = EXMEM_pc_i[HISTORY_WIDTH+1:2] ^ EXMEM_ghr_i;
    assign w_pht_upd    = EXMEM_valid_i && EXMEM_is_br_i;
    assign w_btb_wr     = EXMEM_valid_i && w_ex_ctl && EXMEM_taken_i;
    assign w_ex_btb_idx = EXMEM_pc_i[INDEX_WIDTH+1:2];

    // A fetched cond hit only advances history when no recovery is under way.
    assign w_if_cond_shift = !w_mispredict && IF_valid_i && w_if_hit &&
                             (w_if_entry.btype == BR_COND);

    // Decode the BTB entry type; return/call classes outrank plain jumps.
    always_comb begin
        w_ex_type = BR_COND;
        if (EXMEM_is_ret_i) begin
            w_ex_type = BR_RET;
        end else if (EXMEM_is_call_i) begin
            w_ex_type = BR_CALL;
        end else if (EXMEM_is_jmp_i) begin
            w_ex_type = BR_UNCOND;
        end
    end

    assign w_ex_entry.valid  = 1'b1;
    assign w_ex_entry.tag    = c_BTB_TAG_MAX'(EXMEM_pc_i[31:INDEX_WIDTH+2]);
    assign w_ex_entry.target = EXMEM_target_i;
    assign w_ex_entry.btype  = w_ex_type;

    // Next-PC select: commit-side redirect outranks the fetch prediction.
    always_comb begin
        w_sel = SEL_IF_PC4;
        if (w_mispredict && EXMEM_taken_i) begin
            w_sel = SEL_EXMEM_TARGET;
        end else if (w_mispredict) begin
            w_sel = SEL_EXMEM_PC4;
        end else if (w_if_pred) begin
            w_sel = SEL_IF_TARGET;
        end
    end

    // ------------------------------------------------------------------
    // Return target source
    // ------------------------------------------------------------------
`ifdef RAS_EN
    logic        w_ras_push;
    logic        w_ras_pop;
    logic [31:0] w_ras_top;
    logic        w_ras_empty;

    assign w_ras_push = !w_mispredict && IF_valid_i && w_if_hit &&
                        (w_if_entry.btype == BR_CALL);
    assign w_ras_pop  = !w_mispredict && IF_valid_i && w_if_hit &&
                        (w_if_entry.btype == BR_RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_addr (IF_pc_i + 32'd4),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

    // An empty stack falls back to the BTB target.
    assign IF_target_o = (w_if_hit && (w_if_entry.btype == BR_RET) && !w_ras_empty)
                       ? w_ras_top : w_if_entry.target;
`else
    assign IF_target_o = w_if_entry.target;
`endif

    // PC alignment bits never index anything; stack depth only matters with RAS_EN.
    logic w_unused;
    assign w_unused = ^{IF_pc_i[1:0], EXMEM_pc_i[1:0], (RAS_DEPTH > 0)};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IF_btb_hit_o    = w_if_hit;
    assign IF_prediction_o = w_if_pred;
    assign IF_ghr_o        = r_spec_ghr;
    assign IF_PCnext_sel_o = w_sel;
    assign IF_flush_o      = w_mispredict;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Speculative history: repaired from the commit snapshot on a cond
    // mispredict, otherwise advanced by fetched cond predictions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_spec_ghr <= '0;
        end else if (w_mispredict && EXMEM_is_br_i) begin
            r_spec_ghr <= {EXMEM_ghr_i[HISTORY_WIDTH-2:0], EXMEM_taken_i};
        end else if (w_if_cond_shift) begin
            r_spec_ghr <= {r_spec_ghr[HISTORY_WIDTH-2:0], w_if_pred};
        end
    end

    // PHT training with saturating counters at commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_PHT_ENTRIES; i++) begin
                r_pht[i] <= c_CTR_RESET;
            end
        end else if (w_pht_upd) begin
            if (EXMEM_taken_i) begin
                if (r_pht[w_ex_pht_idx] != c_CTR_MAX) begin
                    r_pht[w_ex_pht_idx] <= r_pht[w_ex_pht_idx] + CTR_WIDTH'(1);
                end
            end else begin
                if (r_pht[w_ex_pht_idx] != '0) begin
                    r_pht[w_ex_pht_idx] <= r_pht[w_ex_pht_idx] - CTR_WIDTH'(1);
                end
            end
        end
    end

    // BTB allocation/refresh on every committed taken control transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_BTB_ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (w_btb_wr) begin
            r_btb[w_ex_btb_idx] <= w_ex_entry;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_spec_predictor.sv
// ============================================================================
//  Module      : tb_gshare_spec_predictor
//  Description : Scoreboard bench for gshare_spec_predictor. The driver pushes
//                hand-computed expectations tagged with a sample slot; a
//                monitor samples the outputs mid-cycle and late-cycle and
//                compares against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gshare_spec_predictor;

    localparam bit [5:0] M_HIT  = 6'h01;
    localparam bit [5:0] M_PRED = 6'h02;
    localparam bit [5:0] M_TGT  = 6'h04;
    localparam bit [5:0] M_SEL  = 6'h08;
    localparam bit [5:0] M_FL   = 6'h10;
    localparam bit [5:0] M_GHR  = 6'h20;
    localparam bit [5:0] M_ALL  = 6'h3f;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] IF_pc_i;
    logic        IF_valid_i;
    logic        EXMEM_valid_i;
    logic [31:0] EXMEM_pc_i;
    logic        EXMEM_is_br_i;
    logic        EXMEM_is_jmp_i;
    logic        EXMEM_is_call_i;
    logic        EXMEM_is_ret_i;
    logic        EXMEM_taken_i;
    logic [31:0] EXMEM_target_i;
    logic        EXMEM_prediction_i;
    logic [31:0] EXMEM_pred_target_i;
    logic [7:0]  EXMEM_ghr_i;
    logic        IF_btb_hit_o;
    logic        IF_prediction_o;
    logic [31:0] IF_target_o;
    logic [7:0]  IF_ghr_o;
    logic [1:0]  IF_PCnext_sel_o;
    logic        IF_flush_o;

    gshare_spec_predictor dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .IF_pc_i             (IF_pc_i),
        .IF_valid_i          (IF_valid_i),
        .EXMEM_valid_i       (EXMEM_valid_i),
        .EXMEM_pc_i          (EXMEM_pc_i),
        .EXMEM_is_br_i       (EXMEM_is_br_i),
        .EXMEM_is_jmp_i      (EXMEM_is_jmp_i),
        .EXMEM_is_call_i     (EXMEM_is_call_i),
        .EXMEM_is_ret_i      (EXMEM_is_ret_i),
        .EXMEM_taken_i       (EXMEM_taken_i),
        .EXMEM_target_i      (EXMEM_target_i),
        .EXMEM_prediction_i  (EXMEM_prediction_i),
        .EXMEM_pred_target_i (EXMEM_pred_target_i),
        .EXMEM_ghr_i         (EXMEM_ghr_i),
        .IF_btb_hit_o        (IF_btb_hit_o),
        .IF_prediction_o     (IF_prediction_o),
        .IF_target_o         (IF_target_o),
        .IF_ghr_o            (IF_ghr_o),
        .IF_PCnext_sel_o     (IF_PCnext_sel_o),
        .IF_flush_o          (IF_flush_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          slot;
        string       name;
        bit [5:0]    mask;
        bit          hit;
        bit          pred;
        logic [31:0] tgt;
        logic [1:0]  sel;
        bit          flush;
        logic [7:0]  ghr;
    } exp_t;

    exp_t sb_q[$];

    // ph 0: sampled at the falling edge; ph 1: sampled 2 ns before the next rise.
    task automatic expect_out(input int ph, input string name, input bit [5:0] mask,
                              input bit hit, input bit pred, input logic [31:0] tgt,
                              input logic [1:0] sel, input bit flush, input logic [7:0] ghr);
        exp_t e;
        e.slot = cyc * 2 + ph;
        e.name = name;
        e.mask = mask;
        e.hit = hit;
        e.pred = pred;
        e.tgt = tgt;
        e.sel = sel;
        e.flush = flush;
        e.ghr = ghr;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h (t=%0t)", name, field, act, exp, $time);
        end
    endtask

    task automatic check_slot(input int slot);
        while (sb_q.size() > 0 && sb_q[0].slot <= slot) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.slot < slot) begin
                checks++;
                failures++;
                $display("FAIL %s: not sampled, slot %0d now %0d", e.name, e.slot, slot);
            end else begin
                if (e.mask & M_HIT)  cmp(e.name, "hit",   32'(IF_btb_hit_o),    32'(e.hit));
                if (e.mask & M_PRED) cmp(e.name, "pred",  32'(IF_prediction_o), 32'(e.pred));
                if (e.mask & M_TGT)  cmp(e.name, "tgt",   IF_target_o,          e.tgt);
                if (e.mask & M_SEL)  cmp(e.name, "sel",   32'(IF_PCnext_sel_o), 32'(e.sel));
                if (e.mask & M_FL)   cmp(e.name, "flush", 32'(IF_flush_o),      32'(e.flush));
                if (e.mask & M_GHR)  cmp(e.name, "ghr",   32'(IF_ghr_o),        32'(e.ghr));
            end
        end
    endtask

    // Monitor: compares DUT outputs against the queue at both sample points.
    initial begin
        forever begin
            @(negedge clk_i);
            check_slot(cyc * 2);
            #3;
            check_slot(cyc * 2 + 1);
        end
    end

    task automatic idle();
        IF_pc_i = 32'h0;
        IF_valid_i = 1'b0;
        EXMEM_valid_i = 1'b0;
        EXMEM_pc_i = 32'h0;
        EXMEM_is_br_i = 1'b0;
        EXMEM_is_jmp_i = 1'b0;
        EXMEM_is_call_i = 1'b0;
        EXMEM_is_ret_i = 1'b0;
        EXMEM_taken_i = 1'b0;
        EXMEM_target_i = 32'h0;
        EXMEM_prediction_i = 1'b0;
        EXMEM_pred_target_i = 32'h0;
        EXMEM_ghr_i = 8'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic commit(input logic [31:0] pc, input bit br, input bit jmp,
                          input bit call, input bit ret, input bit taken,
                          input logic [31:0] tgt, input bit pred,
                          input logic [31:0] ptgt, input logic [7:0] ghr);
        EXMEM_valid_i = 1'b1;
        EXMEM_pc_i = pc;
        EXMEM_is_br_i = br;
        EXMEM_is_jmp_i = jmp;
        EXMEM_is_call_i = call;
        EXMEM_is_ret_i = ret;
        EXMEM_taken_i = taken;
        EXMEM_target_i = tgt;
        EXMEM_prediction_i = pred;
        EXMEM_pred_target_i = ptgt;
        EXMEM_ghr_i = ghr;
    endtask

    task automatic fetch(input logic [31:0] pc, input bit vld);
        IF_pc_i = pc;
        IF_valid_i = vld;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state with both stages idle.
        fetch(32'h100, 1'b0);
        expect_out(0, "reset_state", M_ALL & ~M_TGT, 0, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();

        // Two correctly predicted taken commits of 0x100: counter 01->10->11.
        for (int k = 0; k < 2; k++) begin
            commit(32'h100, 1, 0, 0, 0, 1, 32'h200, 1, 32'h200, 8'h00);
            expect_out(0, "train_0x100", M_HIT | M_SEL | M_FL, 0, 0, 0, 2'b00, 0, 8'h00);
            next_cycle();
        end
        fetch(32'h100, 1'b0);
        expect_out(0, "hit_0x100", M_ALL, 1, 1, 32'h200, 2'b10, 0, 8'h00);
        next_cycle();

        // Five increments at 0x180 saturate at 11.
        for (int k = 0; k < 5; k++) begin
            commit(32'h180, 1, 0, 0, 0, 1, 32'h280, 1, 32'h280, 8'h00);
            expect_out(0, "inc_0x180", M_SEL | M_FL, 0, 0, 0, 2'b00, 0, 8'h00);
            next_cycle();
        end
        fetch(32'h180, 1'b0);
        expect_out(0, "sat_hi", M_HIT | M_PRED | M_TGT | M_SEL, 1, 1, 32'h280, 2'b10, 0, 8'h00);
        next_cycle();
        commit(32'h180, 1, 0, 0, 0, 0, 32'h280, 0, 32'h0, 8'h00);
        expect_out(0, "dec_nt_ok", M_SEL | M_FL, 0, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();
        fetch(32'h180, 1'b0);
        expect_out(0, "after_dec1", M_PRED | M_SEL, 1, 1, 0, 2'b10, 0, 8'h00);
        next_cycle();
        commit(32'h180, 1, 0, 0, 0, 0, 32'h280, 0, 32'h0, 8'h00);
        next_cycle();
        fetch(32'h180, 1'b0);
        expect_out(0, "after_dec2", M_HIT | M_PRED | M_SEL, 1, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();

        // Four decrements from 01 floor at 00.
        for (int k = 0; k < 4; k++) begin
            commit(32'h180, 1, 0, 0, 0, 0, 32'h280, 0, 32'h0, 8'h00);
            next_cycle();
        end
        commit(32'h180, 1, 0, 0, 0, 1, 32'h280, 1, 32'h280, 8'h00);
        next_cycle();
        fetch(32'h180, 1'b0);
        expect_out(0, "floor_inc1", M_PRED | M_SEL, 1, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();
        commit(32'h180, 1, 0, 0, 0, 1, 32'h280, 1, 32'h280, 8'h00);
        next_cycle();
        fetch(32'h180, 1'b0);
        expect_out(0, "floor_inc2", M_PRED | M_SEL, 1, 1, 0, 2'b10, 0, 8'h00);
        next_cycle();

        // Not-taken mispredict alongside a fetched cond hit.
        commit(32'h300, 1, 0, 0, 0, 0, 32'h0, 1, 32'h304, 8'h5A);
        fetch(32'h100, 1'b1);
        expect_out(0, "mispred_nt", M_ALL, 1, 1, 32'h200, 2'b01, 1, 8'h00);
        next_cycle();
        expect_out(0, "ghr_repair", M_GHR | M_FL | M_SEL, 0, 0, 0, 2'b00, 0, 8'hB4);
        next_cycle();

        // Fetched cond hit shifts its prediction (PHT[0x40^0xB4] is 01 -> 0).
        fetch(32'h100, 1'b1);
        expect_out(0, "fetch_shift", M_HIT | M_PRED | M_SEL | M_GHR, 1, 0, 0, 2'b00, 0, 8'hB4);
        next_cycle();
        expect_out(0, "ghr_shifted", M_GHR, 0, 0, 0, 2'b00, 0, 8'h68);
        next_cycle();

        // Wrong-target jump: taken redirect, history untouched.
        commit(32'h404, 0, 1, 0, 0, 1, 32'h800, 1, 32'h700, 8'h33);
        expect_out(0, "mispred_tk", M_SEL | M_FL | M_GHR, 0, 0, 0, 2'b11, 1, 8'h68);
        next_cycle();
        fetch(32'h404, 1'b0);
        expect_out(0, "uncond_hit", M_ALL, 1, 1, 32'h800, 2'b10, 0, 8'h68);
        next_cycle();

        // Return with empty/absent stack uses the BTB target.
        commit(32'h408, 0, 1, 0, 1, 1, 32'h999C, 1, 32'h999C, 8'h68);
        expect_out(0, "ret_commit", M_SEL | M_FL, 0, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();
        fetch(32'h408, 1'b1);
        expect_out(0, "ret_btb_tgt", M_HIT | M_PRED | M_TGT | M_SEL | M_GHR,
                   1, 1, 32'h999C, 2'b10, 0, 8'h68);
        next_cycle();

        // Asynchronous reset mid-cycle with a BTB write pending.
        commit(32'h50C, 1, 0, 0, 0, 1, 32'h600, 1, 32'h600, 8'h00);
        fetch(32'h100, 1'b0);
        expect_out(0, "pre_rst_hit", M_HIT | M_TGT | M_FL, 1, 0, 32'h200, 2'b00, 0, 8'h00);
        expect_out(1, "async_rst", M_HIT | M_PRED | M_SEL | M_FL | M_GHR, 0, 0, 0, 2'b00, 0, 8'h00);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        fetch(32'h100, 1'b0);
        expect_out(0, "post_rst_old", M_HIT | M_PRED | M_SEL | M_GHR, 0, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();
        fetch(32'h50C, 1'b0);
        expect_out(0, "post_rst_pend", M_HIT | M_SEL, 0, 0, 0, 2'b00, 0, 8'h00);
        next_cycle();

`ifdef RAS_EN
        // Five calls overflow a 4-deep stack; five returns drain it.
        for (int k = 1; k <= 5; k++) begin
            commit(32'(k * 16), 0, 1, 1, 0, 1, 32'h1000, 1, 32'h1000, 8'h00);
            expect_out(0, "call_commit", M_FL, 0, 0, 0, 2'b00, 0, 8'h00);
            next_cycle();
        end
        commit(32'h60, 0, 1, 0, 1, 1, 32'hABC0, 1, 32'hABC0, 8'h00);
        next_cycle();
        for (int k = 1; k <= 5; k++) begin
            fetch(32'(k * 16), 1'b1);
            expect_out(0, "call_fetch", M_HIT | M_PRED | M_TGT, 1, 1, 32'h1000, 2'b10, 0, 8'h00);
            next_cycle();
        end
        begin
            logic [31:0] ret_exp [5];
            ret_exp[0] = 32'h54;
            ret_exp[1] = 32'h44;
            ret_exp[2] = 32'h34;
            ret_exp[3] = 32'h24;
            ret_exp[4] = 32'hABC0;
            for (int k = 0; k < 5; k++) begin
                fetch(32'h60, 1'b1);
                expect_out(0, "ret_pop", M_HIT | M_TGT, 1, 1, ret_exp[k], 2'b10, 0, 8'h00);
                next_cycle();
            end
        end
`endif

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk_i);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
